uart_rx: RTL and testbench

- Serial receive front end for the board's USB-UART line.
- Oversamples the asynchronous `rx` pin at 16x baud and recovers 8N1 frames, LSB first.
- Each good byte is presented on `rx_data` with a one-cycle `rx_done_tick`, which drives `write_to_fifo` / `write_data_in` of the 32-byte receive FIFO directly downstream.
- Bad frames are flagged and never written to the FIFO.

---
 rtl/uart_rx_pkg.sv | 14 +
 rtl/uart_rx_baud_gen.sv | 25 ++
 rtl/uart_rx.sv | 126 ++++++++++++
 tb/tb_uart_rx.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared UART receive/transmit state encodings and baud constants.
package uart_rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } rx_state_t;

    localparam int OVERSAMPLE       = 16;
    localparam int DEFAULT_BAUD_DIV = 651;

endpackage

// File: rtl/uart_rx_baud_gen.sv
// baud_gen: free-running divider producing a one-cycle tick at 16x the baud rate.
module baud_gen
    import uart_rx_pkg::*;
#(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
    input  logic clk_100MHz,
    input  logic reset,
    output logic tick
);

    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    logic [CW-1:0] count;

    assign tick = count == CW'(BAUD_DIV - 1);

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset)
            count <= '0;
        else
            count <= tick ? '0 : count + 1'b1;
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x oversampling 8N1 receiver; flags bad stop bits and pulses done per good byte.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int SB_TICKS  = 16,
    parameter int BAUD_DIV  = DEFAULT_BAUD_DIV
) (
    input  logic                 clk_100MHz,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done_tick,
    output logic                 frame_error,
    output logic                 busy
);

    localparam int SW = (SB_TICKS > 16) ? 5 : 4;
    localparam int NW = $clog2(DATA_BITS);

    logic                 tick;
    logic                 rx_meta, rx_s, rx_prev;
    rx_state_t            state, state_next;
    logic [SW-1:0]        s, s_next;
    logic [NW-1:0]        n, n_next;
    logic [DATA_BITS-1:0] shift, shift_next, rx_data_next;
    logic                 done_next, ferr_next;

    baud_gen #(.BAUD_DIV(BAUD_DIV)) u_baud_gen (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .tick       (tick)
    );

    // Sync flops reset to the idle level so release does not look like a start edge by itself.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            s            <= '0;
            n            <= '0;
            shift        <= '0;
            rx_data      <= '0;
            rx_done_tick <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            state        <= state_next;
            s            <= s_next;
            n            <= n_next;
            shift        <= shift_next;
            rx_data      <= rx_data_next;
            rx_done_tick <= done_next;
            frame_error  <= ferr_next;
        end
    end

    always_comb begin
        state_next   = state;
        s_next       = s;
        n_next       = n;
        shift_next   = shift;
        rx_data_next = rx_data;
        done_next    = 1'b0;
        ferr_next    = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s && rx_prev) begin
                    state_next = START;
                    s_next     = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (s == SW'(7)) begin
                        state_next = rx_s ? IDLE : DATA;
                        s_next     = '0;
                        n_next     = '0;
                    end else begin
                        s_next = s + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s == SW'(15)) begin
                        shift_next = {rx_s, shift[DATA_BITS-1:1]};
                        s_next     = '0;
                        if (n == NW'(DATA_BITS - 1))
                            state_next = STOP;
                        else
                            n_next = n + 1'b1;
                    end else begin
                        s_next = s + 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (s == SW'(SB_TICKS - 1)) begin
                        state_next   = IDLE;
                        rx_data_next = rx_s ? shift : rx_data;
                        done_next    = rx_s;
                        ferr_next    = !rx_s;
                    end else begin
                        s_next = s + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = state != IDLE;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frame tests for uart_rx using a short baud divider.
module tb_uart_rx;

    localparam int BDIV = 5;
    localparam int CPB  = BDIV * 16;

    logic       clk_100MHz = 1'b0;
    logic       reset      = 1'b1;
    logic       rx         = 1'b1;
    logic [7:0] rx_data;
    logic       rx_done_tick, frame_error, busy;

    int checks = 0, failures = 0;
    int done_cnt = 0, ferr_cnt = 0, both_cnt = 0;
    logic [7:0] rx_q[$];

    uart_rx #(.DATA_BITS(8), .SB_TICKS(16), .BAUD_DIV(BDIV)) dut (
        .clk_100MHz   (clk_100MHz),
        .reset        (reset),
        .rx           (rx),
        .rx_data      (rx_data),
        .rx_done_tick (rx_done_tick),
        .frame_error  (frame_error),
        .busy         (busy)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    always @(posedge clk_100MHz) begin
        if (rx_done_tick) begin
            done_cnt++;
            rx_q.push_back(rx_data);
        end
        if (frame_error) ferr_cnt++;
        if (rx_done_tick && frame_error) both_cnt++;
    end

    task automatic send_frame(input logic [7:0] d, input int cpb, input logic stop);
        rx = 1'b0;
        repeat (cpb) @(negedge clk_100MHz);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (cpb) @(negedge clk_100MHz);
        end
        rx = stop;
        repeat (cpb) @(negedge clk_100MHz);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        rx    = 1'b1;
        repeat (4) @(negedge clk_100MHz);
        checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
        checks++; if (rx_done_tick !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", rx_done_tick); end
        checks++; if (frame_error !== 1'b0) begin failures++; $display("FAIL reset_ferr got=%b exp=0", frame_error); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        reset = 1'b0;
        repeat (CPB) @(negedge clk_100MHz);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_byte;
        int d0 = done_cnt, f0 = ferr_cnt;
        fork
            send_frame(8'hA5, CPB, 1'b1);
            begin
                repeat (5) @(negedge clk_100MHz);
                checks++; if (busy !== 1'b1) begin failures++; $display("FAIL byte_busy got=%b exp=1", busy); end
            end
        join
        repeat (CPB) @(negedge clk_100MHz);
        checks++; if (rx_data !== 8'hA5) begin failures++; $display("FAIL byte_data got=%h exp=a5", rx_data); end
        checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL byte_done_count got=%0d exp=1", done_cnt - d0); end
        checks++; if (ferr_cnt - f0 !== 0) begin failures++; $display("FAIL byte_ferr_count got=%0d exp=0", ferr_cnt - f0); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL byte_busy_after got=%b exp=0", busy); end
    endtask

    task automatic test_back_to_back;
        int d0 = done_cnt, f0 = ferr_cnt;
        rx_q.delete();
        for (int i = 0; i < 32; i++) send_frame(8'(i), CPB, 1'b1);
        repeat (2 * CPB) @(negedge clk_100MHz);
        checks++; if (done_cnt - d0 !== 32) begin failures++; $display("FAIL b2b_fifo_writes got=%0d exp=32", done_cnt - d0); end
        checks++; if (ferr_cnt - f0 !== 0) begin failures++; $display("FAIL b2b_ferr got=%0d exp=0", ferr_cnt - f0); end
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (i >= rx_q.size()) begin
                failures++; $display("FAIL b2b_data[%0d] got=none exp=%h", i, 8'(i));
            end else if (rx_q[i] !== 8'(i)) begin
                failures++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, rx_q[i], 8'(i));
            end
        end
    endtask

    task automatic test_glitch;
        int d0 = done_cnt, f0 = ferr_cnt;
        rx = 1'b0;
        repeat (3 * BDIV) @(negedge clk_100MHz);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk_100MHz);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL glitch_busy got=%b exp=0", busy); end
        checks++; if (done_cnt - d0 !== 0) begin failures++; $display("FAIL glitch_done got=%0d exp=0", done_cnt - d0); end
        checks++; if (ferr_cnt - f0 !== 0) begin failures++; $display("FAIL glitch_ferr got=%0d exp=0", ferr_cnt - f0); end
        send_frame(8'h3C, CPB, 1'b1);
        repeat (CPB) @(negedge clk_100MHz);
        checks++; if (rx_data !== 8'h3C) begin failures++; $display("FAIL glitch_next_data got=%h exp=3c", rx_data); end
        checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL glitch_next_done got=%0d exp=1", done_cnt - d0); end
    endtask

    task automatic test_frame_error;
        int d0 = done_cnt, f0 = ferr_cnt;
        send_frame(8'h55, CPB, 1'b0);
        repeat (2 * CPB) @(negedge clk_100MHz);
        checks++; if (ferr_cnt - f0 !== 1) begin failures++; $display("FAIL ferr_count got=%0d exp=1", ferr_cnt - f0); end
        checks++; if (done_cnt - d0 !== 0) begin failures++; $display("FAIL ferr_done got=%0d exp=0", done_cnt - d0); end
        checks++; if (rx_data !== 8'h3C) begin failures++; $display("FAIL ferr_rx_data got=%h exp=3c", rx_data); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ferr_low_line_busy got=%b exp=0", busy); end
        rx = 1'b1;
        repeat (CPB) @(negedge clk_100MHz);
        send_frame(8'h5A, CPB, 1'b1);
        repeat (CPB) @(negedge clk_100MHz);
        checks++; if (rx_data !== 8'h5A) begin failures++; $display("FAIL ferr_next_data got=%h exp=5a", rx_data); end
    endtask

    task automatic test_reset_mid_frame;
        int d0, f0;
        rx = 1'b0;
        repeat (CPB) @(negedge clk_100MHz);
        rx = 1'b1;
        repeat (4 * CPB) @(negedge clk_100MHz);
        rx = 1'b0;
        repeat (CPB / 2) @(negedge clk_100MHz);
        reset = 1'b1;
        repeat (3) @(negedge clk_100MHz);
        checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL mid_reset_data got=%h exp=00", rx_data); end
        checks++; if (rx_done_tick !== 1'b0) begin failures++; $display("FAIL mid_reset_done got=%b exp=0", rx_done_tick); end
        checks++; if (frame_error !== 1'b0) begin failures++; $display("FAIL mid_reset_ferr got=%b exp=0", frame_error); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_reset_busy got=%b exp=0", busy); end
        d0 = done_cnt;
        f0 = ferr_cnt;
        reset = 1'b0;
        repeat (6 * BDIV) @(negedge clk_100MHz);
        rx = 1'b1;
        repeat (12 * CPB) @(negedge clk_100MHz);
        checks++; if (done_cnt - d0 !== 0) begin failures++; $display("FAIL mid_post_done got=%0d exp=0", done_cnt - d0); end
        checks++; if (ferr_cnt - f0 !== 0) begin failures++; $display("FAIL mid_post_ferr got=%0d exp=0", ferr_cnt - f0); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_post_busy got=%b exp=0", busy); end
        send_frame(8'h81, CPB, 1'b1);
        repeat (CPB) @(negedge clk_100MHz);
        checks++; if (rx_data !== 8'h81) begin failures++; $display("FAIL mid_next_data got=%h exp=81", rx_data); end
        checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL mid_next_done got=%0d exp=1", done_cnt - d0); end
    endtask

    task automatic test_baud_tolerance;
        int f0 = ferr_cnt;
        int d0 = done_cnt;
        send_frame(8'h96, CPB - 2, 1'b1);
        repeat (CPB) @(negedge clk_100MHz);
        checks++; if (rx_data !== 8'h96) begin failures++; $display("FAIL fast_data got=%h exp=96", rx_data); end
        rx_q.delete();
        send_frame(8'h69, CPB + 2, 1'b1);
        repeat (CPB) @(negedge clk_100MHz);
        checks++; if (rx_data !== 8'h69) begin failures++; $display("FAIL slow_data got=%h exp=69", rx_data); end
        send_frame(8'h96, CPB + 2, 1'b1);
        repeat (CPB) @(negedge clk_100MHz);
        checks++; if (rx_data !== 8'h96) begin failures++; $display("FAIL slow_data2 got=%h exp=96", rx_data); end
        checks++; if (ferr_cnt - f0 !== 0) begin failures++; $display("FAIL tol_ferr got=%0d exp=0", ferr_cnt - f0); end
        checks++; if (done_cnt - d0 !== 3) begin failures++; $display("FAIL tol_done got=%0d exp=3", done_cnt - d0); end
    endtask

    task automatic test_pulse_exclusive;
        checks++; if (both_cnt !== 0) begin failures++; $display("FAIL pulse_overlap got=%0d exp=0", both_cnt); end
    endtask

    initial begin
        @(negedge clk_100MHz);
        test_reset;
        test_byte;
        test_back_to_back;
        test_glitch;
        test_frame_error;
        test_reset_mid_frame;
        test_baud_tolerance;
        test_pulse_exclusive;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
